dcache_mem_bridge: RTL



---
 rtl/dcache_mem_bridge_pkg.sv | 29 ++
 rtl/dcache_mem_bridge.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_bridge_pkg.sv
// Shared definitions for the dcache <-> main memory line bridge:
// line geometry, bridge FSM state encoding and the latched request record.
package dcache_mem_bridge_pkg;

   localparam int DCACHE_ADDR_WIDTH     = 32;
   localparam int DCACHE_LINE_WIDTH     = 128;
   localparam int DCACHE_DATA_WIDTH     = 32;
   localparam int DCACHE_BEATS_PER_LINE = DCACHE_LINE_WIDTH / DCACHE_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } type_mem_bridge_state_e;

   // Request as captured in IDLE; data doubles as the line buffer.
   typedef struct packed {
      logic                         wr;
      logic [DCACHE_ADDR_WIDTH-1:0] addr;
      logic [DCACHE_LINE_WIDTH-1:0] data;
   } type_mem_bridge_req_s;

   // Width of a counter that must reach 'timeout' without wrapping.
   // A disabled timeout (0) still gets a 1-bit counter so no vector is empty.
   function automatic int wait_cnt_width(input int timeout);
      return (timeout <= 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/dcache_mem_bridge.sv
// Memory-side responder for the dcache line interface. A line refill or
// writeback is split into word beats on the memory bus, beat 0 carrying
// line bits [31:0] at the line base address. The dcache gets a single-cycle
// ack (with the refill line, or an error flag if a beat timed out).
module dcache_mem_bridge
   import dcache_mem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = DCACHE_ADDR_WIDTH,
   parameter int LINE_WIDTH     = DCACHE_LINE_WIDTH,
   parameter int WORD_WIDTH     = DCACHE_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dcache2mem_req_i,
   input  logic                  dcache2mem_wr_i,
   input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
   input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
   output logic                  mem2dcache_ack_o,
   output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
   output logic                  mem2dcache_err_o,
   output logic                  busy_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [WORD_WIDTH-1:0] bus_wdata_o,
   output logic [3:0]            bus_sel_o,
   input  logic                  bus_ack_i,
   input  logic [WORD_WIDTH-1:0] bus_rdata_i
);

   localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WAIT_W = wait_cnt_width(TIMEOUT_CYCLES);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
   // Counter value seen on the final permitted wait cycle of a beat.
   localparam logic [WAIT_W-1:0] TIMEOUT_LAST =
      (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

   type_mem_bridge_state_e state_reg, state_next;
   type_mem_bridge_req_s   req_reg;
   logic [BEAT_W-1:0]      beat_reg;
   logic [WAIT_W-1:0]      wait_cnt_reg;
   logic                   err_reg;
   logic                   blocked_reg;

   logic                   accept;
   logic                   last_beat;
   logic                   timeout_hit;
   logic [WORD_WIDTH-1:0]  line_word [BEATS];

   // Line address offset bits are dropped on capture.
   logic unused_addr_bits;
   assign unused_addr_bits = ^dcache2mem_addr_i[3:0];

   // The cycle right after RESP ignores the request, which the dcache may
   // still be holding from the transaction that just completed.
   assign accept      = (state_reg == IDLE) && dcache2mem_req_i && !blocked_reg;
   assign last_beat   = (beat_reg == LAST_BEAT);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_reg == TIMEOUT_LAST);

   // Word view of the line buffer for the write-beat mux.
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
      assign line_word[gi] = req_reg.data[gi*WORD_WIDTH +: WORD_WIDTH];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic; an ack on the last permitted wait cycle beats the timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = BEAT;
         BEAT: begin
            if (bus_ack_i) begin
               if (last_beat) state_next = RESP;
            end else if (timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture, line buffer fill, beat and wait counters, error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_reg      <= '0;
         beat_reg     <= '0;
         wait_cnt_reg <= '0;
         err_reg      <= 1'b0;
         blocked_reg  <= 1'b0;
      end else begin
         blocked_reg <= (state_reg == RESP);
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  req_reg.wr   <= dcache2mem_wr_i;
                  req_reg.addr <= {dcache2mem_addr_i[ADDR_WIDTH-1:4], 4'b0000};
                  req_reg.data <= dcache2mem_wr_i ? dcache2mem_data_i : '0;
                  beat_reg     <= '0;
                  wait_cnt_reg <= '0;
                  err_reg      <= 1'b0;
               end
            end
            BEAT: begin
               if (bus_ack_i) begin
                  if (!req_reg.wr)
                     req_reg.data[beat_reg*WORD_WIDTH +: WORD_WIDTH] <= bus_rdata_i;
                  if (!last_beat) beat_reg <= beat_reg + 1'b1;
                  wait_cnt_reg <= '0;
               end else if (timeout_hit) begin
                  err_reg      <= 1'b1;
                  req_reg.data <= '0;
               end else if (wait_cnt_reg != WAIT_MAX) begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            RESP:    err_reg <= 1'b0;
            default: ;
         endcase
      end
   end

   // Outputs decoded from the current state; everything idles at zero.
   always_comb begin
      mem2dcache_ack_o  = 1'b0;
      mem2dcache_err_o  = 1'b0;
      mem2dcache_data_o = '0;
      busy_o            = (state_reg != IDLE);
      bus_req_o         = 1'b0;
      bus_we_o          = 1'b0;
      bus_addr_o        = '0;
      bus_wdata_o       = '0;
      bus_sel_o         = 4'h0;
      case (state_reg)
         BEAT: begin
            bus_req_o   = 1'b1;
            bus_we_o    = req_reg.wr;
            bus_addr_o  = req_reg.addr + ADDR_WIDTH'({beat_reg, 2'b00});
            bus_wdata_o = line_word[beat_reg];
            bus_sel_o   = 4'hF;
         end
         RESP: begin
            mem2dcache_ack_o  = 1'b1;
            mem2dcache_err_o  = err_reg;
            mem2dcache_data_o = req_reg.wr ? '0 : req_reg.data;
         end
         default: ;
      endcase
   end

endmodule
